// File: rtl/hssim_pkg.sv
// Shared constants and types for the HSSIM fuse/select stage.
// Frame geometry, beat width and HSSIM latency live here so every stage agrees on them.
package hssim_pkg;

    localparam int PIXELS_PER_BEAT = 16;
    localparam int IMAGE_DIM       = 512;
    localparam int HSSIM_LAT       = 12;
    localparam int DATA_WIDTH      = 8 * PIXELS_PER_BEAT;
    localparam int BEATS_PER_ROW   = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int COUNT_WIDTH     = $clog2(IMAGE_DIM * IMAGE_DIM) + 1;
    localparam int COL_WIDTH       = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int ROW_WIDTH       = $clog2(IMAGE_DIM);
    localparam int SEL_CNT_WIDTH   = $clog2(PIXELS_PER_BEAT + 1);

    typedef logic [SEL_CNT_WIDTH-1:0] sel_cnt_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] new_pix;
        logic [DATA_WIDTH-1:0] old_pix;
    } pix_pair_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic                  first;
    } out_beat_t;

    // Number of pixels in a beat that were taken from the new frame.
    function automatic sel_cnt_t count_selected(input logic [PIXELS_PER_BEAT-1:0] sel);
        sel_cnt_t n;
        n = '0;
        for (int j = 0; j < PIXELS_PER_BEAT; j++) begin
            n = n + sel_cnt_t'(sel[j]);
        end
        return n;
    endfunction

endpackage

// File: rtl/hssim_fuse_select_fifo.sv
// Two-entry beat buffer with occupancy and next-occupancy outputs.
// Generic over payload width so other stages can reuse it.
module beat_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count,
    output logic [1:0]       count_next
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && (count != 2'd2);

    always_comb begin
        // NOTE: count_next gets its default first so no path leaves it unassigned (no latch).
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 2'd1;
        end else if (pop_ok && !push_ok) begin
            count_next = count - 2'd1;
        end
    end

    // NOTE: storage is reset here because the head drives an output port directly;
    // delay-line payload elsewhere stays unreset and is qualified by its valid bit.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/hssim_fuse_select.sv
// Aligns image beats with the HSSIM decision map, selects new/old pixels per byte,
// and emits fused beats on AXI-Stream with row/frame markers and per-frame new-pixel counts.
module hssim_fuse_select
    import hssim_pkg::*;
(
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  new_pix,
    input  logic [DATA_WIDTH-1:0]  old_pix,
    input  logic [DATA_WIDTH-1:0]  del,
    output logic                   stall,
    output logic [DATA_WIDTH-1:0]  m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   m_tuser,
    output logic [COUNT_WIDTH-1:0] new_count,
    output logic                   new_count_vld
);

    logic                  advance;
    logic [HSSIM_LAT-1:0]  pipe_vld;
    pix_pair_t             pipe_pix [HSSIM_LAT];
    logic [DATA_WIDTH-1:0] sel_pix;
    logic [PIXELS_PER_BEAT-1:0] sel_new;
    logic                  sel_vld;
    logic [DATA_WIDTH-1:0] sel_data;
    sel_cnt_t              sel_cnt;
    logic                  push;
    logic                  pop;
    logic [COL_WIDTH-1:0]  col_beat;
    logic [ROW_WIDTH-1:0]  row;
    logic                  row_end;
    logic                  frame_end;
    logic [COUNT_WIDTH-1:0] acc;
    logic [COUNT_WIDTH-1:0] acc_sum;
    out_beat_t             push_beat;
    out_beat_t             head_beat;
    logic [1:0]            fifo_count;
    logic [1:0]            fifo_count_next;

    assign advance = ~stall;

    // Alignment delay line: matches the HSSIM latency and freezes with it.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pipe_vld <= '0;
        end else if (advance) begin
            pipe_vld <= {pipe_vld[HSSIM_LAT-2:0], s_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            pipe_pix[0] <= {new_pix, old_pix};
            for (int i = 1; i < HSSIM_LAT; i++) begin
                pipe_pix[i] <= pipe_pix[i-1];
            end
        end
    end

    // Only the MSB of each decision byte matters, so off-nominal values still resolve.
    always_comb begin
        sel_new = '0;
        sel_pix = '0;
        for (int j = 0; j < PIXELS_PER_BEAT; j++) begin
            sel_new[j]         = del[8*j+7];
            sel_pix[8*j +: 8]  = sel_new[j] ? pipe_pix[HSSIM_LAT-1].new_pix[8*j +: 8]
                                            : pipe_pix[HSSIM_LAT-1].old_pix[8*j +: 8];
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sel_vld <= 1'b0;
        end else if (advance) begin
            sel_vld <= pipe_vld[HSSIM_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            sel_data <= sel_pix;
            sel_cnt  <= count_selected(sel_new);
        end
    end

    assign push      = sel_vld & advance;
    assign pop       = m_tvalid & m_tready;
    assign row_end   = (col_beat == COL_WIDTH'(BEATS_PER_ROW - 1));
    assign frame_end = row_end && (row == ROW_WIDTH'(IMAGE_DIM - 1));

    // Position tracks what is written into the buffer, not what leaves it.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            col_beat <= '0;
            row      <= '0;
        end else if (push) begin
            if (row_end) begin
                col_beat <= '0;
                row      <= frame_end ? '0 : row + 1'b1;
            end else begin
                col_beat <= col_beat + 1'b1;
            end
        end
    end

    assign acc_sum = acc + COUNT_WIDTH'(sel_cnt);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            acc           <= '0;
            new_count     <= '0;
            new_count_vld <= 1'b0;
        end else begin
            new_count_vld <= 1'b0;
            if (push) begin
                if (frame_end) begin
                    new_count     <= acc_sum;
                    new_count_vld <= 1'b1;
                    acc           <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    assign push_beat = '{data: sel_data, last: row_end, first: (row == '0) && (col_beat == '0)};

    beat_fifo2 #(
        .WIDTH($bits(out_beat_t))
    ) u_out_buf (
        .clk        (clk),
        .aresetn    (aresetn),
        .push       (push),
        .push_data  (push_beat),
        .pop        (pop),
        .head_data  (head_beat),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    // Freeze as soon as the buffer will be full; it can never take a third beat.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stall <= 1'b0;
        end else begin
            stall <= (fifo_count_next == 2'd2);
        end
    end

    assign s_ready  = ~stall;
    assign m_tvalid = (fifo_count != 2'd0);
    assign m_tdata  = head_beat.data;
    assign m_tlast  = head_beat.last;
    assign m_tuser  = head_beat.first;

endmodule

// File: tb/tb_hssim_fuse_select.sv
// Randomized bench for hssim_fuse_select: a transaction-level model predicts the fused
// stream, buffer occupancy, markers and frame counts, and is compared every cycle.
module tb_hssim_fuse_select;
    import hssim_pkg::*;

    localparam int BPF = BEATS_PER_ROW * IMAGE_DIM;

    logic                   clk = 1'b0;
    logic                   aresetn = 1'b0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic [DATA_WIDTH-1:0]  new_pix = '0;
    logic [DATA_WIDTH-1:0]  old_pix = '0;
    logic [DATA_WIDTH-1:0]  del = '0;
    logic                   stall;
    logic [DATA_WIDTH-1:0]  m_tdata;
    logic                   m_tvalid;
    logic                   m_tready = 1'b0;
    logic                   m_tlast;
    logic                   m_tuser;
    logic [COUNT_WIDTH-1:0] new_count;
    logic                   new_count_vld;

    hssim_fuse_select dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .new_pix       (new_pix),
        .old_pix       (old_pix),
        .del           (del),
        .stall         (stall),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tlast       (m_tlast),
        .m_tuser       (m_tuser),
        .new_count     (new_count),
        .new_count_vld (new_count_vld)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DATA_WIDTH-1:0] act,
                         input logic [DATA_WIDTH-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        bit                    last;
        bit                    first;
    } exp_beat_t;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        int                    nsel;
        int                    rem;
    } flight_t;

    exp_beat_t             mq[$];
    flight_t               fl[$];
    logic [DATA_WIDTH-1:0] hs [HSSIM_LAT];
    logic [DATA_WIDTH-1:0] cur_del = '0;
    longint                pushes = 0;
    longint                acc = 0;
    longint                exp_count = 0;
    bit                    exp_vld = 0;

    int edge_no = 0;
    int first_acc_edge = -1;
    int first_vld_edge = -1;
    int stall_cycles = 0;
    int dut_pulses = 0;
    int dut_last_pops = 0;
    int dut_first_pops = 0;
    bit armed = 0;
    bit first_pop_user = 0;

    function automatic logic [DATA_WIDTH-1:0] fuse(input logic [DATA_WIDTH-1:0] n,
                                                   input logic [DATA_WIDTH-1:0] o,
                                                   input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        for (int j = 0; j < PIXELS_PER_BEAT; j++)
            r[8*j +: 8] = (d[8*j +: 8] >= 8'd128) ? n[8*j +: 8] : o[8*j +: 8];
        return r;
    endfunction

    function automatic int n_selected(input logic [DATA_WIDTH-1:0] d);
        int n = 0;
        for (int j = 0; j < PIXELS_PER_BEAT; j++)
            if (d[8*j +: 8] >= 8'd128) n++;
        return n;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] make_del(input int mode);
        logic [DATA_WIDTH-1:0] d;
        for (int j = 0; j < PIXELS_PER_BEAT; j++) begin
            case (mode)
                1:       d[8*j +: 8] = (j % 2 == 1) ? 8'hFF : 8'h00;
                2:       d[8*j +: 8] = 8'hFF;
                3:       d[8*j +: 8] = ($urandom_range(1) == 1) ? 8'h80 : 8'h7F;
                4:       d[8*j +: 8] = 8'($urandom_range(255));
                default: d[8*j +: 8] = ($urandom_range(1) == 1) ? 8'hFF : 8'h00;
            endcase
        end
        return d;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rand_beat();
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH / 32; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic model_clear();
        mq.delete();
        fl.delete();
        for (int k = 0; k < HSSIM_LAT; k++) hs[k] = '0;
        pushes    = 0;
        acc       = 0;
        exp_count = 0;
        exp_vld   = 0;
    endtask

    task automatic compare_outputs();
        check("m_tvalid", m_tvalid, mq.size() != 0);
        check("stall", stall, mq.size() == 2);
        check("s_ready", s_ready, mq.size() != 2);
        check("new_count_vld", new_count_vld, exp_vld);
        check("new_count", new_count, exp_count);
        if (mq.size() != 0 && m_tvalid) begin
            check("m_tdata", m_tdata, mq[0].data);
            check("m_tlast", m_tlast, mq[0].last);
            check("m_tuser", m_tuser, mq[0].first);
        end
        if (stall) stall_cycles++;
        if (new_count_vld) dut_pulses++;
        if (m_tvalid && first_vld_edge < 0) first_vld_edge = edge_no - 1;
        if (m_tvalid && m_tready) begin
            if (m_tlast) dut_last_pops++;
            if (m_tuser) dut_first_pops++;
            if (armed) begin
                first_pop_user = m_tuser;
                armed = 0;
            end
        end
    endtask

    // Advances the model across the coming rising edge.
    task automatic model_step();
        bit        st;
        bit        pop;
        bit        do_push;
        flight_t   f;
        flight_t   nf;
        exp_beat_t b;
        longint    pos;
        st      = (mq.size() == 2);
        pop     = (mq.size() != 0) && m_tready;
        do_push = 0;
        if (!st) begin
            foreach (fl[i]) fl[i].rem--;
            if (fl.size() != 0 && fl[0].rem == 0) begin
                f = fl[0];
                fl.delete(0);
                do_push = 1;
            end
        end
        if (pop) mq.delete(0);
        exp_vld = 0;
        if (do_push) begin
            pos     = pushes % BPF;
            b.data  = f.data;
            b.last  = ((pos % BEATS_PER_ROW) == BEATS_PER_ROW - 1);
            b.first = (pos == 0);
            acc += f.nsel;
            if (pos == BPF - 1) begin
                exp_count = acc;
                exp_vld   = 1;
                acc       = 0;
            end
            pushes++;
            mq.push_back(b);
        end
        if (s_valid && !st) begin
            if (first_acc_edge < 0) first_acc_edge = edge_no;
            nf.data = fuse(new_pix, old_pix, cur_del);
            nf.nsel = n_selected(cur_del);
            nf.rem  = HSSIM_LAT + 1;
            fl.push_back(nf);
        end
        if (!st) begin
            for (int k = HSSIM_LAT - 1; k > 0; k--) hs[k] = hs[k-1];
            hs[0] = cur_del;
        end
    endtask

    always @(negedge clk) begin
        edge_no++;
        if (!aresetn) begin
            model_clear();
            armed = 1;
            check("rst_m_tvalid", m_tvalid, 1'b0);
            check("rst_stall", stall, 1'b0);
            check("rst_new_count", new_count, '0);
            check("rst_new_count_vld", new_count_vld, 1'b0);
            check("rst_m_tdata", m_tdata, '0);
        end else begin
            compare_outputs();
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int vprob, input int rprob, input int dmode);
        @(posedge clk);
        #1;
        s_valid  = ($urandom_range(99) < vprob);
        new_pix  = rand_beat();
        old_pix  = rand_beat();
        cur_del  = make_del(dmode);
        del      = hs[HSSIM_LAT-1];
        m_tready = ($urandom_range(99) < rprob);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        aresetn = 1'b0;
        #1;
        check("async_rst_m_tvalid", m_tvalid, 1'b0);
        check("async_rst_stall", stall, 1'b0);
        check("async_rst_new_count_vld", new_count_vld, 1'b0);
        check("async_rst_new_count", new_count, '0);
        s_valid = 1'b0;
        del     = '0;
        cur_del = '0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc0;
        int p0;
        int l0;
        int u0;
        int p1;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;

        // Continuous stream, alternating old/new per pixel, never backpressured.
        sc0 = stall_cycles;
        repeat (60) drive(100, 100, 1);
        check("first_out_latency", first_vld_edge - first_acc_edge, 13);
        check("no_stall_streaming", stall_cycles - sc0, 0);

        // Ten cycles of backpressure mid-stream.
        repeat (10) drive(100, 0, 1);
        repeat (30) drive(100, 100, 0);
        check("stall_seen_backpressure", (stall_cycles - sc0) > 0, 1'b1);

        // Off-nominal decision bytes 0x80 / 0x7F.
        repeat (80) drive(60, 70, 3);

        // Random bubbles and ready.
        for (int i = 0; i < 1500; i++) drive(70, 60, ($urandom_range(1) == 1) ? 0 : 4);
        check("no_pulse_partial_frame", dut_pulses, 0);

        // Full frame with every pixel taken from the new frame.
        mid_reset();
        p0 = dut_pulses;
        l0 = dut_last_pops;
        u0 = dut_first_pops;
        repeat (BPF) drive(100, 100, 2);
        repeat (20) drive(0, 100, 2);
        check("frame_pulses", dut_pulses - p0, 1);
        check("frame_new_count", new_count, 262144);
        check("frame_tlast_pops", dut_last_pops - l0, 512);
        check("frame_tuser_pops", dut_first_pops - u0, 1);

        // Start of the next frame, then abort it with a reset.
        repeat (300) drive(80, 70, 0);
        check("frame2_tuser_pops", dut_first_pops - u0, 2);
        p1 = dut_pulses;
        mid_reset();
        repeat (60) drive(90, 90, 4);
        check("post_reset_first_tuser", first_pop_user, 1'b1);
        check("no_pulse_aborted_frame", dut_pulses - p1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
